// File: rtl/nibble_tx_pkg.sv
// Shared definitions for the nibble sender: FSM state encoding, nibble
// width, default timing constants and a nibble-count helper.
package nibble_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    RELEASE = 3'd2,
    GAP     = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam int NIBBLE_W        = 4;
  localparam int DEF_ACK_TIMEOUT = 255;
  localparam int DEF_MAX_RETRY   = 3;
  localparam int DEF_GAP_CYCLES  = 2;

  // Number of nibbles carried by one word.
  function automatic int nibble_count(input int word_w);
    return word_w / NIBBLE_W;
  endfunction

endpackage

// File: rtl/hs_timer.sv
// Saturating wait counter used for ack timeouts and inter-nibble gaps.
//   clk, reset : clock and asynchronous active-high reset
//   clr        : restart counting from zero (has priority over en)
//   en         : count one cycle
//   limit      : number of cycles to wait (0 means already expired)
//   expired    : the current cycle is the limit-th counted cycle
module hs_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of cycles already completed, so the limit-th
  // cycle is the one where cnt == limit-1; the owner acts at its end.
  assign expired = (limit == '0) || (cnt >= limit - ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/nibble_sender.sv
// Sends each accepted word as WORD_W/4 nibbles, MSB nibble first, over a
// four-phase valid/ack handshake with ack timeout, bounded retry, sticky
// error flag and a completed-word counter.
//   clk, reset            : clock, asynchronous active-high reset
//   word_in, word_valid   : word from the acquisition side
//   word_ready            : sender idle and able to take a word
//   data_out, valid, ack  : nibble handshake to the receiver
//   busy                  : a word is in flight
//   word_done             : one-cycle pulse after the last nibble is released
//   err, clr_err          : sticky abort flag and its clear
//   words_sent            : wrapping count of completed words
module nibble_sender
  import nibble_tx_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int MAX_RETRY   = DEF_MAX_RETRY,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORD_W-1:0]   word_in,
  input  logic                word_valid,
  output logic                word_ready,
  output logic [NIBBLE_W-1:0] data_out,
  output logic                valid,
  input  logic                ack,
  output logic                busy,
  output logic                word_done,
  output logic                err,
  input  logic                clr_err,
  output logic [15:0]         words_sent
);

  localparam int N       = nibble_count(WORD_W);
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  localparam logic [15:0]        ACK_LIM   = 16'(ACK_TIMEOUT);
  localparam logic [15:0]        GAP_LIM   = 16'(GAP_CYCLES);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  state_t              state;
  logic [WORD_W-1:0]   shreg;
  logic [WORD_W-1:0]   shreg_nxt;
  logic [IDX_W-1:0]    nib_idx;
  logic [RETRY_W-1:0]  retry_cnt;
  logic                retry_pend;
  logic                last_try;
  logic                tmr_clr;
  logic                tmr_en;
  logic                tmr_exp;
  logic [15:0]         tmr_limit;

  assign shreg_nxt = shreg << NIBBLE_W;

  // The timeout that fires now is the one that uses up the last retry.
  assign last_try = (32'(retry_cnt) + 32'd1) >= 32'(MAX_RETRY);

  // One timer serves both the ack waits and the gap; it is restarted on
  // every cycle that leaves its state so each state starts from zero.
  assign tmr_limit = (state == GAP) ? GAP_LIM : ACK_LIM;
  assign tmr_en    = (state == SEND) || (state == RELEASE) || (state == GAP);

  always_comb begin
    tmr_clr = 1'b1;
    case (state)
      SEND:    tmr_clr = ack || tmr_exp;
      RELEASE: tmr_clr = !ack || tmr_exp;
      GAP:     tmr_clr = tmr_exp;
      default: tmr_clr = 1'b1;
    endcase
  end

  hs_timer #(
    .CNT_W (16)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .limit   (tmr_limit),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      nib_idx    <= '0;
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
      word_ready <= 1'b1;
      data_out   <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      word_done  <= 1'b0;
      err        <= 1'b0;
      words_sent <= '0;
    end else begin
      word_done <= 1'b0;
      // A new error below overrides this clear in the same cycle.
      if (clr_err) err <= 1'b0;

      case (state)
        IDLE: begin
          if (word_valid) begin
            shreg      <= word_in;
            data_out   <= word_in[WORD_W-1 -: NIBBLE_W];
            nib_idx    <= LAST_IDX;
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
            valid      <= 1'b1;
            busy       <= 1'b1;
            word_ready <= 1'b0;
            state      <= SEND;
          end
        end

        SEND: begin
          if (ack) begin
            valid <= 1'b0;
            state <= RELEASE;
          end else if (tmr_exp) begin
            valid <= 1'b0;
            if (last_try) begin
              err      <= 1'b1;
              data_out <= '0;
              shreg    <= '0;
              state    <= ERROR;
            end else begin
              retry_cnt  <= retry_cnt + RETRY_ONE;
              retry_pend <= 1'b1;
              state      <= GAP;
            end
          end
        end

        RELEASE: begin
          if (!ack) begin
            state <= GAP;
          end else if (tmr_exp) begin
            err      <= 1'b1;
            data_out <= '0;
            shreg    <= '0;
            state    <= ERROR;
          end
        end

        GAP: begin
          if (tmr_exp) begin
            if (retry_pend) begin
              // Resend the same nibble; data_out was never changed.
              retry_pend <= 1'b0;
              valid      <= 1'b1;
              state      <= SEND;
            end else if (nib_idx != '0) begin
              nib_idx   <= nib_idx - IDX_ONE;
              shreg     <= shreg_nxt;
              data_out  <= shreg_nxt[WORD_W-1 -: NIBBLE_W];
              retry_cnt <= '0;
              valid     <= 1'b1;
              state     <= SEND;
            end else begin
              word_done  <= 1'b1;
              words_sent <= words_sent + 16'd1;
              busy       <= 1'b0;
              word_ready <= 1'b1;
              state      <= IDLE;
            end
          end
        end

        ERROR: begin
          busy       <= 1'b0;
          word_ready <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
